dft_npoint_seq: RTL and testbench

//  Parametrised sequential N-point complex DFT/IDFT engine; generalises the fixed 4-point DFT to any power-of-2 N.

---
 rtl/dft_pkg.sv | 37 +++
 rtl/dft_twiddle_rom.sv | 30 +++
 rtl/dft_npoint_seq.sv | 187 ++++++++++++++++++
 tb/tb_dft_npoint_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared types and elaboration-time helpers for the sequential N-point DFT engine.
// No logic of its own: FSM encoding, datapath width helpers, twiddle ROM contents.
// Backpressure: n/a.
package dft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam real PI = 3.14159265358979323846;

  // Full-precision width of one real x twiddle product.
  function automatic int prod_width(input int dw, input int tw);
    return dw + tw;
  endfunction

  // Accumulator width: N summed complex products (two products per term) never overflow.
  function automatic int acc_width(input int dw, input int tw, input int log2n);
    return dw + tw + log2n + 1;
  endfunction

  // Twiddle entry m of an n-point table, amplitude 2^(tw-1)-1, rounded to nearest.
  // Only ever evaluated at elaboration to build constant ROM contents.
  function automatic int twiddle_val(input int m, input int n, input int tw, input bit is_sin);
    real amp;
    real ang;
    real v;
    amp = real'((1 << (tw - 1)) - 1);
    ang = 2.0 * PI * real'(m) / real'(n);
    v   = is_sin ? amp * $sin(ang) : amp * $cos(ang);
    return int'(v);
  endfunction

endpackage

// File: rtl/dft_twiddle_rom.sv
// Twiddle ROM: cos/sin of 2*pi*m/N in Q1.(TW-1), contents fixed at elaboration.
// Latency: combinational read.
// Backpressure: n/a.
module dft_twiddle_rom
  import dft_pkg::*;
#(
  parameter int N  = 8,
  parameter int TW = 16,
  localparam int LOG2N = $clog2(N)
) (
  input  logic        [LOG2N-1:0] m,
  output logic signed [TW-1:0]    cos_val,
  output logic signed [TW-1:0]    sin_val
);

  logic signed [TW-1:0] cos_tab [N];
  logic signed [TW-1:0] sin_tab [N];

  // One constant entry per table slot; the sign of sin is applied later by the MAC.
  for (genvar g = 0; g < N; g++) begin : g_tab
    localparam int COS_V = twiddle_val(g, N, TW, 1'b0);
    localparam int SIN_V = twiddle_val(g, N, TW, 1'b1);
    assign cos_tab[g] = TW'(COS_V);
    assign sin_tab[g] = TW'(SIN_V);
  end

  assign cos_val = cos_tab[m];
  assign sin_val = sin_tab[m];

endmodule

// File: rtl/dft_npoint_seq.sv
// Sequential N-point complex DFT/IDFT: load N samples, one complex MAC per cycle, stream N bins out.
// Latency: N*(N+1) compute cycles after the last input sample, then one bin per accepted output cycle.
// Backpressure: in_ready only in LOAD; bins held stable while out_ready is low.
module dft_npoint_seq
  import dft_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int TW = 16,
  localparam int LOG2N = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    inverse,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_re,
  input  logic signed [DW-1:0]    in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_re,
  output logic signed [DW-1:0]    out_im,
  output logic        [LOG2N-1:0] out_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = prod_width(DW, TW);
  localparam int AW = acc_width(DW, TW, LOG2N);
  localparam int SH = TW - 1 + LOG2N;

  localparam logic        [LOG2N:0]   CNT_WR   = (LOG2N+1)'(N);
  localparam logic        [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic signed [AW:0]      RND      = (AW+1)'(1) << (SH - 1);
  localparam logic signed [AW:0]      SAT_MAX  = (AW+1)'(2**(DW-1) - 1);
  localparam logic signed [AW:0]      SAT_MIN  = -SAT_MAX - (AW+1)'(1);

  state_t state, state_nxt;

  // cnt: sample index in LOAD; MAC index 0..N-1 plus write slot N in COMPUTE.
  logic        [LOG2N:0]   cnt;
  // k_idx: bin being accumulated in COMPUTE, bin being presented in OUTPUT.
  logic        [LOG2N-1:0] k_idx;
  // m_idx: running (k*n) mod N, wraps naturally in LOG2N bits.
  logic        [LOG2N-1:0] m_idx;
  logic                    inv_q;
  logic signed [AW-1:0]    acc_re, acc_im;

  logic signed [DW-1:0] x_re [N];
  logic signed [DW-1:0] x_im [N];
  logic signed [DW-1:0] y_re [N];
  logic signed [DW-1:0] y_im [N];

  logic signed [TW-1:0] cos_val, sin_val, sin_eff;
  logic signed [DW-1:0] xr_cur, xi_cur;
  logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
  logic signed [AW-1:0] term_re, term_im;
  logic                 wr_slot;

  // Divide by N with round-half-up, then clamp to the signed output range.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW-1:0] a);
    logic signed [AW:0] r;
    logic signed [AW:0] q;
    r = (AW+1)'(a) + RND;
    q = r >>> SH;
    if (q > SAT_MAX)      return DW'(SAT_MAX);
    else if (q < SAT_MIN) return DW'(SAT_MIN);
    else                  return DW'(q);
  endfunction

  dft_twiddle_rom #(.N(N), .TW(TW)) u_rom (
    .m       (m_idx),
    .cos_val (cos_val),
    .sin_val (sin_val)
  );

  // IDFT conjugates the twiddle: flip sin. ROM magnitude is 2^(TW-1)-1, so negation fits.
  assign sin_eff = inv_q ? -sin_val : sin_val;
  assign xr_cur  = x_re[cnt[LOG2N-1:0]];
  assign xi_cur  = x_im[cnt[LOG2N-1:0]];
  assign p_rc    = PW'(xr_cur) * PW'(cos_val);
  assign p_is    = PW'(xi_cur) * PW'(sin_eff);
  assign p_ic    = PW'(xi_cur) * PW'(cos_val);
  assign p_rs    = PW'(xr_cur) * PW'(sin_eff);
  assign term_re = AW'(p_rc) + AW'(p_is);
  assign term_im = AW'(p_ic) - AW'(p_rs);
  assign wr_slot = (state == COMPUTE) && (cnt == CNT_WR);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode for IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (in_valid && (cnt[LOG2N-1:0] == IDX_LAST)) state_nxt = COMPUTE;
      COMPUTE: if (wr_slot && (k_idx == IDX_LAST)) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready && (k_idx == IDX_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and result outputs are pure functions of state; IDLE drives everything to 0.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    out_re    = '0;
    out_im    = '0;
    out_idx   = '0;
    case (state)
      LOAD:   in_ready = 1'b1;
      OUTPUT: begin
        out_valid = 1'b1;
        out_re    = y_re[k_idx];
        out_im    = y_im[k_idx];
        out_idx   = k_idx;
      end
      default: ;
    endcase
  end

  // Counters, mode latch, accumulators and the done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      k_idx  <= '0;
      m_idx  <= '0;
      inv_q  <= 1'b0;
      acc_re <= '0;
      acc_im <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          inv_q  <= inverse;
          cnt    <= '0;
          k_idx  <= '0;
          m_idx  <= '0;
          acc_re <= '0;
          acc_im <= '0;
        end
        LOAD: if (in_valid) begin
          cnt <= (cnt[LOG2N-1:0] == IDX_LAST) ? '0 : cnt + (LOG2N+1)'(1);
        end
        COMPUTE: begin
          if (cnt == CNT_WR) begin
            cnt    <= '0;
            k_idx  <= k_idx + LOG2N'(1);
            m_idx  <= '0;
            acc_re <= '0;
            acc_im <= '0;
          end else begin
            acc_re <= acc_re + term_re;
            acc_im <= acc_im + term_im;
            m_idx  <= m_idx + k_idx;
            cnt    <= cnt + (LOG2N+1)'(1);
          end
        end
        OUTPUT: if (out_ready) begin
          k_idx <= k_idx + LOG2N'(1);
          if (k_idx == IDX_LAST) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sample and result buffers; contents after an aborted frame are irrelevant, so no reset.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && in_valid) begin
      x_re[cnt[LOG2N-1:0]] <= in_re;
      x_im[cnt[LOG2N-1:0]] <= in_im;
    end
    if (wr_slot) begin
      y_re[k_idx] <= scale_sat(acc_re);
      y_im[k_idx] <= scale_sat(acc_im);
    end
  end

endmodule

// File: tb/tb_dft_npoint_seq.sv
// Bench for dft_npoint_seq: directed frames pinned by hand values, then randomized frames.
// Expected bins come from a direct DFT sum over quantized twiddles with 1/N round-half-up and saturation.
// A single negedge monitor checks every valid output cycle, stall stability, done and compute length.
module tb_dft_npoint_seq;
  localparam int N     = 8;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int LOG2N = 3;
  localparam real PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, busy, done;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic signed [DW-1:0] out_re, out_im;
  logic [LOG2N-1:0] out_idx;

  int tests = 0;
  int fails = 0;
  int xr[N], xi[N], exp_re[N], exp_im[N], cos_t[N], sin_t[N];
  bit mon_en = 1'b0;
  bit stall_mode = 1'b0;
  int exp_k = 0;
  int comp_cycles = 0;
  int done_cnt = 0;
  bit was_stalled = 1'b0;
  logic signed [DW-1:0] prev_re, prev_im;
  logic [LOG2N-1:0] prev_idx;

  dft_npoint_seq #(.N(N), .DW(DW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .inverse(inverse),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req, input int tol);
    tests++;
    if (act > req + tol || act < req - tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, req, tol);
    end
  endtask

  // Reference: X[k] = (1/N) * sum x[n] * W^(kn), quantized twiddles, round-half-up, saturate.
  function automatic int sat_round(input longint a);
    longint q;
    q = (a + (longint'(1) << (TW - 2 + LOG2N))) >>> (TW - 1 + LOG2N);
    if (q > 32767)  return 32767;
    if (q < -32768) return -32768;
    return int'(q);
  endfunction

  task automatic model(input bit inv);
    for (int k = 0; k < N; k++) begin
      longint ar, ai;
      ar = 0;
      ai = 0;
      for (int n = 0; n < N; n++) begin
        int m;
        longint c, s;
        m = (k * n) % N;
        c = cos_t[m];
        s = inv ? -sin_t[m] : sin_t[m];
        ar += xr[n] * c + xi[n] * s;
        ai += xi[n] * c - xr[n] * s;
      end
      exp_re[k] = sat_round(ar);
      exp_im[k] = sat_round(ai);
    end
  endtask

  task automatic set_impulse(input int a);
    for (int n = 0; n < N; n++) begin xr[n] = (n == 0) ? a : 0; xi[n] = 0; end
  endtask

  task automatic set_dc(input int a);
    for (int n = 0; n < N; n++) begin xr[n] = a; xi[n] = 0; end
  endtask

  task automatic set_tone(input bit use_sin);
    for (int n = 0; n < N; n++) begin
      real ang;
      ang = 2.0 * PI * n / N;
      xr[n] = use_sin ? int'(8000.0 * $sin(ang)) : int'(8000.0 * $cos(ang));
      xi[n] = 0;
    end
  endtask

  // Sign-of-cos / sign-of-sin square wave at full scale: bin 1 real part exceeds the output range.
  task automatic set_square();
    for (int n = 0; n < N; n++) begin
      real c, s;
      c = $cos(2.0 * PI * n / N);
      s = $sin(2.0 * PI * n / N);
      xr[n] = (c > 0.1) ? 32767 : (c < -0.1) ? -32767 : 0;
      xi[n] = (s > 0.1) ? 32767 : (s < -0.1) ? -32767 : 0;
    end
  endtask

  task automatic set_random();
    logic [15:0] r;
    for (int n = 0; n < N; n++) begin
      r = 16'($urandom); xr[n] = int'($signed(r));
      r = 16'($urandom); xi[n] = int'($signed(r));
    end
  endtask

  task automatic start_and_load(input bit inv, input bit gaps, input bit poke);
    int g;
    exp_k = 0; comp_cycles = 0; done_cnt = 0; was_stalled = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; inverse = inv;
    @(posedge clk); #1;
    start = 1'b0; inverse = 1'($urandom % 2);
    for (int n = 0; n < N; n++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          if (poke) start = 1'($urandom % 2);
          @(posedge clk); #1;
        end
      end
      in_re = 16'(xr[n]);
      in_im = 16'(xi[n]);
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
      check($sformatf("load_ready[%0d]", n), int'(in_ready), 1, 0);
      if (poke) start = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish_frame();
    int g;
    g = 0;
    while (done_cnt == 0 && g < 2000) begin @(negedge clk); #1; g++; end
    check("done_seen", int'(done_cnt > 0), 1, 0);
    repeat (4) @(negedge clk);
    #1;
    check("done_pulses", done_cnt, 1, 0);
    check("bins_out", exp_k, N, 0);
    check("compute_cycles", comp_cycles, N * (N + 1), 0);
    check("idle_busy", int'(busy), 0, 0);
    mon_en = 1'b0;
  endtask

  task automatic run_frame(input bit inv, input bit gaps, input bit poke, input bit stalls);
    stall_mode = stalls;
    start_and_load(inv, gaps, poke);
    finish_frame();
    stall_mode = 1'b0;
  endtask

  // Downstream readiness: always ready, or random toggling when stalls are enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = stall_mode ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Single compare process: every output-valid cycle against the model, stall stability, phase counts.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !in_ready && !out_valid) comp_cycles++;
      if (done) done_cnt++;
      if (was_stalled) begin
        check("stall_valid", int'(out_valid), 1, 0);
        check("stall_re", int'(out_re), int'(prev_re), 0);
        check("stall_im", int'(out_im), int'(prev_im), 0);
        check("stall_idx", int'(out_idx), int'(prev_idx), 0);
      end
      if (out_valid) begin
        if (exp_k < N) begin
          check($sformatf("bin_idx[%0d]", exp_k), int'(out_idx), exp_k, 0);
          check($sformatf("bin_re[%0d]", exp_k), int'(out_re), exp_re[exp_k], 1);
          check($sformatf("bin_im[%0d]", exp_k), int'(out_im), exp_im[exp_k], 1);
        end else begin
          check("bin_overrun", exp_k, N - 1, 0);
        end
        was_stalled = !out_ready;
        prev_re = out_re; prev_im = out_im; prev_idx = out_idx;
        if (out_ready) exp_k++;
      end else begin
        was_stalled = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < N; m++) begin
      cos_t[m] = int'(32767.0 * $cos(2.0 * PI * m / N));
      sin_t[m] = int'(32767.0 * $sin(2.0 * PI * m / N));
    end

    // Reset held with start/in_valid asserted: everything stays quiet.
    reset = 1'b0; start = 1'b1; in_valid = 1'b1; inverse = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_out_re", int'(out_re), 0, 0);
    check("rst_out_im", int'(out_im), 0, 0);
    check("rst_out_idx", int'(out_idx), 0, 0);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; inverse = 1'b0;

    // Impulse DFT: flat spectrum of 1000.
    set_impulse(8000); model(1'b0);
    for (int k = 0; k < N; k++) begin
      check("model_impulse_re", exp_re[k], 1000, 0);
      check("model_impulse_im", exp_im[k], 0, 0);
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // DC DFT: energy only in bin 0.
    set_dc(800); model(1'b0);
    check("model_dc_x0", exp_re[0], 800, 0);
    check("model_dc_x3", exp_re[3], 0, 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // IDFT of an impulse: every bin 100.
    set_impulse(800); model(1'b1);
    check("model_idft_x0", exp_re[0], 100, 0);
    check("model_idft_x5", exp_re[5], 100, 0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);

    // Cosine tone: bins 1 and 7 real 4000.
    set_tone(1'b0); model(1'b0);
    check("model_cos_x1", exp_re[1], 4000, 1);
    check("model_cos_x7", exp_re[7], 4000, 1);
    check("model_cos_x2", exp_re[2], 0, 1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Sine tone: bin 1 imag -4000, bin 7 imag +4000.
    set_tone(1'b1); model(1'b0);
    check("model_sin_x1", exp_im[1], -4000, 1);
    check("model_sin_x7", exp_im[7], 4000, 1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Cosine tone again with input gaps, output stalls and start poked while busy.
    set_tone(1'b0); model(1'b0);
    run_frame(1'b0, 1'b1, 1'b1, 1'b1);

    // Output saturation.
    set_square(); model(1'b0);
    check("model_sat_x1", exp_re[1], 32767, 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort mid-compute, then a clean impulse frame.
    set_random(); model(1'b0);
    start_and_load(1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    repeat (20) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_in_ready", int'(in_ready), 0, 0);
    check("abort_out_valid", int'(out_valid), 0, 0);
    check("abort_out_re", int'(out_re), 0, 0);
    check("abort_out_idx", int'(out_idx), 0, 0);
    check("abort_done", int'(done), 0, 0);
    reset = 1'b1;
    set_impulse(8000); model(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames: random data, mode, gaps, stalls and stray starts.
    for (int r = 0; r < 6; r++) begin
      bit inv;
      inv = 1'($urandom % 2);
      set_random(); model(inv);
      run_frame(inv, 1'b1, 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
